// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (read-only) and the MEM stage,
// sequencing each access over a valid/ready handshake with starvation guard and timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ack,
  output logic                    if_err,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_ack,
  output logic                    dm_err,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM, ACK} state_e;

  state_e                  state_q, state_d;
  logic                    gnt_dm_q, gnt_dm_d;
  logic                    err_q, err_d;
  logic [SW-1:0]           starve_q, starve_d;
  logic [TW-1:0]           wait_q, wait_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]           mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
  logic                    starve_sat;
  logic                    timeout;

  assign starve_sat = (32'(starve_q) == STARVE_LIMIT);
  // wait_q holds the number of earlier grant cycles without ready, so the
  // TIMEOUT_CYCLES-th such cycle is the one that aborts.
  assign timeout    = (TIMEOUT_CYCLES != 0) && (32'(wait_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d     = state_q;
    gnt_dm_d    = gnt_dm_q;
    err_d       = err_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        err_d  = 1'b0;
        wait_d = '0;
        if (dm_req && !(if_req && starve_sat)) begin
          state_d     = GRANT_DM;
          gnt_dm_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr & WORD_MASK;
          mem_wdata_d = dm_we ? dm_wdata : '0;
          mem_be_d    = dm_we ? dm_be : '1;
          if (!if_req)         starve_d = '0;
          else if (!starve_sat) starve_d = starve_q + 1'b1;
        end else if (if_req) begin
          state_d     = GRANT_IF;
          gnt_dm_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr & WORD_MASK;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          starve_d    = '0;
        end else begin
          starve_d = '0;
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (mem_ready) begin
          state_d = ACK;
          if (!mem_we_q) begin
            if (gnt_dm_q) dm_rdata_d = mem_rdata;
            else          if_rdata_d = mem_rdata;
          end
        end else if (timeout) begin
          state_d = ACK;
          err_d   = 1'b1;
          if (gnt_dm_q) dm_rdata_d = '0;
          else          if_rdata_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_dm_q    <= 1'b0;
      err_q       <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_dm_q    <= gnt_dm_d;
      err_q       <= err_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_valid = (state_q == GRANT_IF) || (state_q == GRANT_DM);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = (state_q == ACK) && !gnt_dm_q;
  assign dm_ack    = (state_q == ACK) && gnt_dm_q;
  assign if_err    = if_ack && err_q;
  assign dm_err    = dm_ack && err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory requests and acks,
// a memory responder/monitor and an ack monitor pop and compare as the DUT presents them.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32, DW = 32, BW = 4, TMO = 8, SLIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ack, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_ack, dm_err;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [BW-1:0] dm_be;
  logic          mem_valid, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SLIM), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } mreq_t;
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } ack_t;

  mreq_t mem_exp_q[$];
  ack_t  if_exp_q[$];
  ack_t  dm_exp_q[$];

  int          checks = 0, errors = 0;
  logic [31:0] if_hold = '0, dm_hold = '0;
  int          ready_delay = 1;
  bit          ready_never = 1'b0;
  bit          rsp_fixed_en = 1'b0;
  logic [31:0] rsp_fixed = '0;
  int          vcnt = 0, last_len = 0;
  mreq_t       cur, prev, mexp;
  ack_t        aexp;
  int          lat, lat_a, lat_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: ready after ready_delay valid cycles; read data is addr ^ C0DE0000
  // unless overridden; junk is driven whenever ready is low.
  always @(negedge clk) begin
    cur = {mem_we, mem_addr, mem_be, mem_wdata};
    if (mem_valid) begin
      vcnt++;
      if (vcnt == 1) begin
        if (mem_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got addr %h expected no request", mem_addr);
        end else begin
          mexp = mem_exp_q.pop_front();
          chk("mem_we",    32'(mem_we), 32'(mexp.we));
          chk("mem_addr",  mem_addr,    mexp.addr);
          chk("mem_be",    32'(mem_be), 32'(mexp.be));
          chk("mem_wdata", mem_wdata,   mexp.wdata);
        end
      end else begin
        chk("mem_stable", 32'(cur != prev), 32'(0));
      end
      prev = cur;
    end else begin
      if (vcnt != 0) last_len = vcnt;
      vcnt = 0;
    end
    mem_ready = mem_valid && !ready_never && (vcnt == ready_delay);
    mem_rdata = mem_ready ? (rsp_fixed_en ? rsp_fixed : (mem_addr ^ 32'hC0DE0000)) : 32'h5A5A5A5A;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (if_ack && dm_ack) begin
        checks++; errors++;
        $display("FAIL ack_both: got if_ack=1 dm_ack=1 expected one");
      end
      if (if_ack) begin
        if (if_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_ack_unexpected: got ack expected none");
        end else begin
          aexp = if_exp_q.pop_front();
          chk("if_rdata", if_rdata, aexp.rdata);
          chk("if_err", 32'(if_err), 32'(aexp.err));
          if_hold = aexp.rdata;
        end
      end else begin
        chk("if_rdata_hold", if_rdata, if_hold);
      end
      if (dm_ack) begin
        if (dm_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dm_ack_unexpected: got ack expected none");
        end else begin
          aexp = dm_exp_q.pop_front();
          chk("dm_rdata", dm_rdata, aexp.rdata);
          chk("dm_err", 32'(dm_err), 32'(aexp.err));
          dm_hold = aexp.rdata;
        end
      end else begin
        chk("dm_rdata_hold", dm_rdata, dm_hold);
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    mem_exp_q.push_back({we, addr, be, wdata});
  endtask

  // Called aligned 1 time unit after a rising edge; returns the same way.
  task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_rdata,
                           input logic exp_err, output int latency);
    if_exp_q.push_back({exp_rdata, exp_err});
    if_req  = 1'b1;
    if_addr = addr;
    latency = -1;
    for (int n = 0; n < 60 && latency < 0; n++) begin
      @(negedge clk);
      if (if_ack) latency = n;
    end
    if (latency < 0) begin
      checks++; errors++;
      $display("FAIL if_ack_timeout: got no ack expected ack for addr %h", addr);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_rdata,
                           input logic exp_err, output int latency);
    dm_exp_q.push_back({exp_rdata, exp_err});
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = addr;
    dm_wdata = wdata;
    dm_be    = be;
    latency  = -1;
    for (int n = 0; n < 60 && latency < 0; n++) begin
      @(negedge clk);
      if (dm_ack) latency = n;
    end
    if (latency < 0) begin
      checks++; errors++;
      $display("FAIL dm_ack_timeout: got no ack expected ack for addr %h", addr);
    end
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    @(posedge clk); #1;
    chk("rst_acks",   32'({if_ack, if_err, dm_ack, dm_err, mem_valid, mem_we}), 32'(0));
    chk("rst_if_rd",  if_rdata, 32'h0);
    chk("rst_dm_rd",  dm_rdata, 32'h0);
    chk("rst_maddr",  mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    chk("rst_mbe",    32'(mem_be), 32'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // 1: IF read, single-cycle memory
    rsp_fixed_en = 1'b1; rsp_fixed = 32'hDEADBEEF; ready_delay = 1;
    push_mem(1'b0, 32'h104, 4'hF, 32'h0);
    if_access(32'h104, 32'hDEADBEEF, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd2);
    rsp_fixed_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("t1_if_hold", if_rdata, 32'hDEADBEEF);

    // 2: DM byte store, ready in 5th grant cycle
    ready_delay = 5;
    push_mem(1'b1, 32'h200, 4'h8, 32'hAB000000);
    dm_access(1'b1, 32'h203, 32'hAB000000, 4'h8, 32'h0, 1'b0, lat);
    chk("t2_latency", 32'(lat), 32'd6);
    chk("t2_valid_len", 32'(last_len), 32'd5);

    // 3: both requesting continuously; loads carry junk wdata/be that must be masked
    ready_delay = 1;
    for (int k = 0; k < 4; k++) push_mem(1'b0, 32'h2000 + 32'(4*k), 4'hF, 32'h0);
    push_mem(1'b0, 32'h1000, 4'hF, 32'h0);
    for (int k = 4; k < 8; k++) push_mem(1'b0, 32'h2000 + 32'(4*k), 4'hF, 32'h0);
    push_mem(1'b0, 32'h1004, 4'hF, 32'h0);
    push_mem(1'b0, 32'h2020, 4'hF, 32'h0);
    fork
      begin
        for (int k = 0; k < 2; k++)
          if_access(32'h1000 + 32'(4*k), 32'hC0DE1000 + 32'(4*k), 1'b0, lat_a);
      end
      begin
        for (int k = 0; k < 9; k++)
          dm_access(1'b0, 32'h2000 + 32'(4*k), 32'h11111111, 4'h3,
                    32'hC0DE2000 + 32'(4*k), 1'b0, lat_b);
      end
    join
    chk("t3_mem_q_empty", 32'(mem_exp_q.size()), 32'd0);

    // 4: DM load timeout
    ready_never = 1'b1;
    push_mem(1'b0, 32'h300, 4'hF, 32'h0);
    dm_access(1'b0, 32'h300, 32'h0, 4'h0, 32'h0, 1'b1, lat);
    chk("t4_valid_len", 32'(last_len), 32'd8);
    chk("t4_latency", 32'(lat), 32'd9);
    chk("t4_idle_valid", 32'(mem_valid), 32'(0));

    // IF timeout clears a previously loaded if_rdata
    push_mem(1'b0, 32'h500, 4'hF, 32'h0);
    if_access(32'h500, 32'h0, 1'b1, lat);
    chk("tif_valid_len", 32'(last_len), 32'd8);

    // 6: ready coincides with the timeout cycle
    ready_never = 1'b0; ready_delay = 8;
    push_mem(1'b0, 32'h304, 4'hF, 32'h0);
    dm_access(1'b0, 32'h304, 32'h0, 4'h0, 32'hC0DE0304, 1'b0, lat);
    chk("t6_valid_len", 32'(last_len), 32'd8);

    // 5: reset in the 3rd grant cycle of an IF access
    ready_never = 1'b1;
    push_mem(1'b0, 32'h400, 4'hF, 32'h0);
    if_req = 1'b1; if_addr = 32'h400;
    repeat (3) @(posedge clk);
    #2 chk("t5_valid_before", 32'(mem_valid), 32'(1));
    reset = 1'b0;
    #1;
    chk("t5_valid_drop", 32'(mem_valid), 32'(0));
    chk("t5_acks",   32'({if_ack, if_err, dm_ack, dm_err, mem_we}), 32'(0));
    chk("t5_if_rd",  if_rdata, 32'h0);
    chk("t5_dm_rd",  dm_rdata, 32'h0);
    chk("t5_maddr",  mem_addr, 32'h0);
    chk("t5_mbe",    32'(mem_be), 32'(0));
    if_hold = '0; dm_hold = '0;
    if_req = 1'b0; ready_never = 1'b0; ready_delay = 1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    push_mem(1'b0, 32'h408, 4'hF, 32'h0);
    if_access(32'h40A, 32'hC0DE0408, 1'b0, lat);
    chk("t5_after_latency", 32'(lat), 32'd2);

    repeat (3) @(posedge clk);
    #1 chk("queues_empty", 32'(if_exp_q.size() + dm_exp_q.size() + mem_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
